multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over one shared ALU and one shared instruction/data memory port.
- Drives the datapath muxes and write enables, and selects the immediate format (ImmSrc) for the sign-extension unit each cycle.
- Sits between the instruction register fields and the datapath; memory wait states are handled through a ready handshake.

---
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Optional performance counters are enabled with `define MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
  parameter int OPW = 7,
  parameter int SW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] op,
  input  logic [2:0]     funct3,
  input  logic           funct7b5,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           AdrSrc,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegWrite,
  output logic [1:0]     ResultSrc,
  output logic [1:0]     ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [2:0]     ALUControl,
  output logic [2:0]     ImmSrc,
  output logic           instr_done,
  output logic           illegal_op
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]    cycle_cnt,
  output logic [31:0]    retired_cnt
`endif
);

  localparam logic [SW-1:0] FETCH    = 4'd0;
  localparam logic [SW-1:0] DECODE   = 4'd1;
  localparam logic [SW-1:0] MEMADR   = 4'd2;
  localparam logic [SW-1:0] MEMREAD  = 4'd3;
  localparam logic [SW-1:0] MEMWB    = 4'd4;
  localparam logic [SW-1:0] MEMWRITE = 4'd5;
  localparam logic [SW-1:0] EXECR    = 4'd6;
  localparam logic [SW-1:0] EXECI    = 4'd7;
  localparam logic [SW-1:0] ALUWB    = 4'd8;
  localparam logic [SW-1:0] BRANCH   = 4'd9;
  localparam logic [SW-1:0] JAL      = 4'd10;

  localparam logic [OPW-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPW-1:0] OP_STORE = 7'b0100011;
  localparam logic [OPW-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OPW-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OPW-1:0] OP_BR    = 7'b1100011;
  localparam logic [OPW-1:0] OP_JAL   = 7'b1101111;

  logic [SW-1:0] state_r;
  logic [SW-1:0] next_s;
  logic          pcwrite_s;
  logic          memwrite_s;
  logic          irwrite_s;
  logic          regwrite_s;
  logic          done_s;
  logic          illegal_s;

  // Shared R/I-type ALU decode; sub_en is only honoured for R-type funct3 000.
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  alu_dec = sub_en ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  endfunction

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    next_s     = FETCH;
    pcwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    done_s     = 1'b0;
    illegal_s  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 3'b000;
    case (state_r)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irwrite_s = mem_ready;
        pcwrite_s = mem_ready;
        next_s    = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
        case (op)
          OP_LOAD, OP_STORE: next_s = MEMADR;
          OP_RTYPE:          next_s = EXECR;
          OP_ITYPE:          next_s = EXECI;
          OP_BR:             next_s = BRANCH;
          OP_JAL:            next_s = JAL;
          default: begin
            illegal_s = 1'b1;
            next_s    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_LOAD) ? 3'b000 : 3'b001;
        next_s  = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next_s = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
        next_s     = FETCH;
      end
      MEMWRITE: begin
        // Strobe held for the whole access, retirement only on the ready cycle.
        AdrSrc     = 1'b1;
        memwrite_s = 1'b1;
        done_s     = mem_ready;
        next_s     = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(funct3, funct7b5);
        next_s     = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct3, 1'b0);
        next_s     = ALUWB;
      end
      ALUWB: begin
        regwrite_s = 1'b1;
        done_s     = 1'b1;
        next_s     = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        case (funct3)
          3'b000:  pcwrite_s = zero;
          3'b001:  pcwrite_s = ~zero;
          default: pcwrite_s = 1'b0;
        endcase
        done_s = 1'b1;
        next_s = FETCH;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcwrite_s = 1'b1;
        next_s    = ALUWB;
      end
      default: next_s = FETCH;
    endcase
  end

  // Enables and pulses are suppressed for the whole reset cycle.
  assign PCWrite    = pcwrite_s & ~rst;
  assign MemWrite   = memwrite_s & ~rst;
  assign IRWrite    = irwrite_s & ~rst;
  assign RegWrite   = regwrite_s & ~rst;
  assign instr_done = done_s & ~rst;
  assign illegal_op = illegal_s & ~rst;

`ifdef MULTICYCLE_CTRL_PERF_EN
  // Free-running cycle and retirement counters, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      retired_cnt <= 32'd0;
    end else begin
      cycle_cnt   <= cycle_cnt + 32'd1;
      retired_cnt <= retired_cnt + {31'd0, done_s};
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver queues per-cycle expected controls and CPI,
// an independent monitor compares them against the DUT.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic       instr_done, illegal_op;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res, srca, srcb;
    logic [2:0] alu, imm;
    logic       done, ill;
  } ctl_t;

  localparam logic [6:0] O_LD = 7'b0000011, O_ST = 7'b0100011, O_R = 7'b0110011;
  localparam logic [6:0] O_I = 7'b0010011, O_BR = 7'b1100011, O_JAL = 7'b1101111;

  ctl_t       exp_q[$];
  int         cpi_q[$];
  int         checks = 0, errors = 0;
  bit         started = 1'b0, finished = 1'b0;
  logic [6:0] cur_op = 7'd0;
  logic [2:0] cur_f3 = 3'd0;
  logic       cur_f7 = 1'b0, cur_zero = 1'b0;

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctl_t w_fetch(input logic r);
    ctl_t c = '0;
    c.pcw = r; c.irw = r; c.srcb = 2'b10; c.res = 2'b10;
    return c;
  endfunction

  function automatic ctl_t w_decode(input logic [6:0] o, input logic ill);
    ctl_t c = '0;
    c.srca = 2'b01; c.srcb = 2'b01; c.ill = ill;
    c.imm = (o == O_JAL) ? 3'b011 : 3'b010;
    return c;
  endfunction

  function automatic ctl_t w_memadr(input logic st);
    ctl_t c = '0;
    c.srca = 2'b10; c.srcb = 2'b01; c.imm = st ? 3'b001 : 3'b000;
    return c;
  endfunction

  function automatic ctl_t w_access(input logic wr, input logic r);
    ctl_t c = '0;
    c.adr = 1'b1; c.memw = wr; c.done = wr & r;
    return c;
  endfunction

  function automatic ctl_t w_wb(input logic from_mem);
    ctl_t c = '0;
    c.res = from_mem ? 2'b01 : 2'b00; c.regw = 1'b1; c.done = 1'b1;
    return c;
  endfunction

  function automatic ctl_t w_exec(input logic [2:0] f3, input logic f7, input logic is_imm);
    ctl_t c = '0;
    c.srca = 2'b10; c.srcb = is_imm ? 2'b01 : 2'b00;
    c.alu = alu_of(f3, is_imm ? 1'b0 : f7);
    return c;
  endfunction

  function automatic ctl_t w_branch(input logic [2:0] f3, input logic z);
    ctl_t c = '0;
    c.srca = 2'b10; c.alu = 3'b001; c.done = 1'b1;
    c.pcw = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0);
    return c;
  endfunction

  function automatic ctl_t w_jal();
    ctl_t c = '0;
    c.srca = 2'b01; c.srcb = 2'b10; c.pcw = 1'b1;
    return c;
  endfunction

  function automatic ctl_t mask_rst(input ctl_t e);
    ctl_t c = e;
    c.pcw = 1'b0; c.irw = 1'b0; c.memw = 1'b0; c.regw = 1'b0; c.done = 1'b0; c.ill = 1'b0;
    return c;
  endfunction

  // One clock of stimulus plus its expected control word.
  task automatic step(input ctl_t e, input logic mr, input logic r_v);
    @(posedge clk);
    #1;
    rst = r_v; op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7;
    zero = cur_zero; mem_ready = mr;
    exp_q.push_back(r_v ? mask_rst(e) : e);
    started = 1'b1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic zb, input int fw, input int mw);
    logic r;
    cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_zero = zb;
    case (o)
      O_LD:                 cpi_q.push_back(fw + mw + 5);
      O_ST:                 cpi_q.push_back(fw + mw + 4);
      O_R, O_I, O_JAL:      cpi_q.push_back(fw + 4);
      O_BR:                 cpi_q.push_back(fw + 3);
      default:              cpi_q.push_back(fw + 2);
    endcase
    for (int i = 0; i < fw; i++) step(w_fetch(1'b0), 1'b0, 1'b0);
    step(w_fetch(1'b1), 1'b1, 1'b0);
    r = rnd_bit();
    case (o)
      O_LD: begin
        step(w_decode(o, 1'b0), r, 1'b0);
        step(w_memadr(1'b0), rnd_bit(), 1'b0);
        for (int i = 0; i < mw; i++) step(w_access(1'b0, 1'b0), 1'b0, 1'b0);
        step(w_access(1'b0, 1'b1), 1'b1, 1'b0);
        step(w_wb(1'b1), rnd_bit(), 1'b0);
      end
      O_ST: begin
        step(w_decode(o, 1'b0), r, 1'b0);
        step(w_memadr(1'b1), rnd_bit(), 1'b0);
        for (int i = 0; i < mw; i++) step(w_access(1'b1, 1'b0), 1'b0, 1'b0);
        step(w_access(1'b1, 1'b1), 1'b1, 1'b0);
      end
      O_R, O_I: begin
        step(w_decode(o, 1'b0), r, 1'b0);
        step(w_exec(f3, f7, o == O_I), rnd_bit(), 1'b0);
        step(w_wb(1'b0), rnd_bit(), 1'b0);
      end
      O_BR: begin
        step(w_decode(o, 1'b0), r, 1'b0);
        step(w_branch(f3, zb), rnd_bit(), 1'b0);
      end
      O_JAL: begin
        step(w_decode(o, 1'b0), r, 1'b0);
        step(w_jal(), rnd_bit(), 1'b0);
        step(w_wb(1'b0), rnd_bit(), 1'b0);
      end
      default: step(w_decode(o, 1'b1), r, 1'b0);
    endcase
  endtask

  // Store abandoned by a 3-cycle reset while waiting in its memory access.
  task automatic reset_mid_store();
    logic r;
    cur_op = O_ST; cur_f3 = 3'b010; cur_f7 = 1'b0; cur_zero = 1'b0;
    step(w_fetch(1'b1), 1'b1, 1'b0);
    step(w_decode(O_ST, 1'b0), 1'b0, 1'b0);
    step(w_memadr(1'b1), 1'b0, 1'b0);
    step(w_access(1'b1, 1'b0), 1'b0, 1'b0);
    step(w_access(1'b1, 1'b0), 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      r = rnd_bit();
      step(w_fetch(r), r, 1'b1);
    end
  endtask

  // Monitor: per-cycle control compare plus CPI check on each retirement pulse.
  initial begin
    ctl_t e, act;
    int   cnt = 0;
    int   want;
    forever begin
      @(negedge clk);
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, instr_done, illegal_op};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL ctl t=%0t op=%b got=%b exp=%b", $time, op, act, e);
        end
      end else if (started && !finished) begin
        checks++;
        errors++;
        $display("FAIL underflow t=%0t got=%b exp=<none>", $time, act);
      end
      if (rst === 1'b1) begin
        cnt = 0;
      end else if (started && !finished) begin
        cnt++;
        if (instr_done === 1'b1 || illegal_op === 1'b1) begin
          want = (cpi_q.size() > 0) ? cpi_q.pop_front() : -1;
          checks++;
          if (cnt != want) begin
            errors++;
            $display("FAIL cpi t=%0t op=%b got=%0d exp=%0d", $time, op, cnt, want);
          end
          cnt = 0;
        end
      end
    end
  end

  // Driver: directed cases first, then random instruction mix.
  initial begin
    logic [6:0] o;
    logic [6:0] bad [6];
    bad = '{7'b1110011, 7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000, 7'b1111111};
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    step(w_fetch(1'b0), 1'b0, 1'b1);
    step(w_fetch(1'b1), 1'b1, 1'b1);

    run_instr(O_R, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(O_LD, 3'b010, 1'b0, 1'b0, 0, 2);
    run_instr(O_ST, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(O_BR, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(O_BR, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(O_BR, 3'b001, 1'b0, 1'b0, 0, 0);
    run_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(O_R, 3'b000, 1'b1, 1'b0, 1, 0);
    run_instr(O_I, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(O_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    reset_mid_store();
    run_instr(O_ST, 3'b010, 1'b0, 1'b0, 2, 3);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 6))
        0:       o = O_R;
        1:       o = O_I;
        2:       o = O_LD;
        3:       o = O_ST;
        4:       o = O_BR;
        5:       o = O_JAL;
        default: o = bad[$urandom_range(0, 5)];
      endcase
      run_instr(o, 3'($urandom_range(0, 7)), rnd_bit(), rnd_bit(),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    @(negedge clk);
    #1;
    finished = 1'b1;
    checks++;
    if (exp_q.size() != 0 || cpi_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d exp=0/0", exp_q.size(), cpi_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
